booth_ctrl: RTL

BOOTH_CTRL -- requirements
Module: booth_ctrl

---
 rtl/alu_pkg.sv | 32 +++
 rtl/iter_cnt.sv | 28 ++
 rtl/booth_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the Booth multiply / restoring divide controller.
package alu_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLdM,
    StLdQ,
    StMulAdd,
    StMulShr,
    StDivShl,
    StDivSub,
    StDivFix,
    StOutA,
    StOutQ
  } state_e;

  typedef enum logic {
    OpMul = 1'b0,
    OpDiv = 1'b1
  } op_e;

  typedef enum logic {
    SelA = 1'b0,
    SelQ = 1'b1
  } out_sel_e;

  typedef enum logic {
    AdderAdd = 1'b0,
    AdderSub = 1'b1
  } adder_e;

endpackage

// File: rtl/iter_cnt.sv
// Iteration counter: clear, increment, and a flag on the final iteration (count == WIDTH-1).
module iter_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == CntW'(WIDTH - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM for a shared-datapath Booth radix-2 signed multiplier and unsigned restoring
// divider. Sequences operand loads, WIDTH iterations and the two-beat (A then Q) result handshake.
module booth_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] booth_bits,
  input  logic       a_msb,
  input  logic       m_zero,
  output logic       load_m,
  output logic       load_q,
  output logic       load_a,
  output logic       clr_a,
  output logic       add_sub,
  output logic       shr,
  output logic       shl,
  output logic       q0_set,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sel,
  output logic       busy,
  output logic       err
);

  state_e r_state;
  state_e w_state_d;
  op_e    r_op;
  logic   r_err;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  logic   w_cnt_last;
  logic   w_start_op;
  logic   w_div_zero;

  iter_cnt #(
    .WIDTH(WIDTH)
  ) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_last(w_cnt_last)
  );

  assign w_start_op = (r_state == StIdle) && start;
  // Divide by zero is known once M is loaded; skip straight to returning A=0, Q=dividend.
  assign w_div_zero = (r_state == StLdQ) && in_valid && (r_op == OpDiv) && m_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_op    <= OpMul;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start_op) begin
        r_op  <= op_e'(op);
        r_err <= 1'b0;
      end else if (w_div_zero) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err       = r_err;
  assign busy      = (r_state != StIdle);
  assign w_cnt_clr = (r_state == StLdQ);

  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    load_m    = 1'b0;
    load_q    = 1'b0;
    load_a    = 1'b0;
    clr_a     = 1'b0;
    add_sub   = AdderAdd;
    shr       = 1'b0;
    shl       = 1'b0;
    q0_set    = 1'b0;
    out_valid = 1'b0;
    out_sel   = SelA;
    w_cnt_inc = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StLdM;
      end
      StLdM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_m    = 1'b1;
          w_state_d = StLdQ;
        end
      end
      StLdQ: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_q = 1'b1;
          clr_a  = 1'b1;
          if (w_div_zero)         w_state_d = StOutA;
          else if (r_op == OpMul) w_state_d = StMulAdd;
          else                    w_state_d = StDivShl;
        end
      end
      StMulAdd: begin
        case (booth_bits)
          2'b01: begin
            load_a  = 1'b1;
            add_sub = AdderAdd;
          end
          2'b10: begin
            load_a  = 1'b1;
            add_sub = AdderSub;
          end
          default: ;
        endcase
        w_state_d = StMulShr;
      end
      StMulShr: begin
        shr = 1'b1;
        if (w_cnt_last) begin
          w_state_d = StOutA;
        end else begin
          w_cnt_inc = 1'b1;
          w_state_d = StMulAdd;
        end
      end
      StDivShl: begin
        shl       = 1'b1;
        w_state_d = StDivSub;
      end
      StDivSub: begin
        load_a    = 1'b1;
        add_sub   = AdderSub;
        w_state_d = StDivFix;
      end
      StDivFix: begin
        // Negative trial remainder: add M back; otherwise this quotient bit is 1.
        if (a_msb) begin
          load_a  = 1'b1;
          add_sub = AdderAdd;
        end else begin
          q0_set = 1'b1;
        end
        if (w_cnt_last) begin
          w_state_d = StOutA;
        end else begin
          w_cnt_inc = 1'b1;
          w_state_d = StDivShl;
        end
      end
      StOutA: begin
        out_valid = 1'b1;
        out_sel   = SelA;
        if (out_ready) w_state_d = StOutQ;
      end
      StOutQ: begin
        out_valid = 1'b1;
        out_sel   = SelQ;
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule
